// File: rtl/mul_div_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_iter_pkg
// Description : Shared constants for the iterative multiply/divide unit.
//               Holds the FSM state encoding, the MUL/DIV mode constants and
//               the default operand width. The ALU uses the same MODE_*
//               values when driving the request.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_div_iter_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_MUL  = MUL,
        S_DIV  = DIV,
        S_DONE = DONE
    } state_e;

endpackage : mul_div_iter_pkg
`default_nettype wire

// File: rtl/mul_div_datapath.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_datapath
// Description : Accumulator / remainder registers and the shared adder /
//               subtractor of the iterative multiply/divide unit. Performs
//               one shift-add (MUL) or restoring-division (DIV) step per
//               cycle when step_i is high.
// Ports       : clk      - rising-edge clock
//               rst_n    - synchronous active-low reset
//               load_i   - latch operands and initialise the accumulator
//               step_i   - perform one iteration
//               op_i     - MODE_MUL / MODE_DIV
//               a_i, b_i - multiplicand/dividend, multiplier/divisor
//               acc_o    - current accumulator ({hi, lo} / {R, Q})
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_datapath
    import mul_div_iter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 op_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [2*WIDTH-1:0] r_acc_q;
    logic [2*WIDTH-1:0] w_acc_d;
    // Multiplicand for MUL, divisor for DIV.
    logic [WIDTH-1:0]   r_opnd_q;
    logic [WIDTH-1:0]   w_opnd_d;

    // Adder/subtractor is two bits wider than an operand: one bit for the
    // multiply carry / the bit shifted out of R, one for the borrow sign.
    logic [WIDTH+1:0]   w_lhs;
    logic [WIDTH+1:0]   w_rhs;
    logic [WIDTH+1:0]   w_res;

    always_comb begin
        w_lhs    = '0;
        w_rhs    = '0;
        w_res    = '0;
        w_acc_d  = r_acc_q;
        w_opnd_d = r_opnd_q;

        if (op_i == MODE_DIV) begin
            // R shifted left with the incoming quotient MSB; may need W+1 bits.
            w_lhs = {1'b0, r_acc_q[2*WIDTH-1:WIDTH-1]};
            w_rhs = {2'b00, r_opnd_q};
            w_res = w_lhs - w_rhs;
        end else begin
            w_lhs = {2'b00, r_acc_q[2*WIDTH-1:WIDTH]};
            w_rhs = r_acc_q[0] ? {2'b00, r_opnd_q} : '0;
            w_res = w_lhs + w_rhs;
        end

        if (load_i) begin
            if (op_i == MODE_DIV) begin
                w_acc_d  = {{WIDTH{1'b0}}, a_i};
                w_opnd_d = b_i;
            end else begin
                w_acc_d  = {{WIDTH{1'b0}}, b_i};
                w_opnd_d = a_i;
            end
        end else if (step_i) begin
            if (op_i == MODE_DIV) begin
                if (!w_res[WIDTH+1]) begin
                    w_acc_d = {w_res[WIDTH-1:0], r_acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    w_acc_d = {r_acc_q[2*WIDTH-2:0], 1'b0};
                end
            end else begin
                // {carry, upper + A, lower} shifted right by one.
                w_acc_d = {w_res[WIDTH:0], r_acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc_q  <= '0;
            r_opnd_q <= '0;
        end else begin
            r_acc_q  <= w_acc_d;
            r_opnd_q <= w_opnd_d;
        end
    end

    assign acc_o = r_acc_q;

endmodule : mul_div_datapath
`default_nettype wire

// File: rtl/mul_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_iter
// Description : Iterative unsigned multiply/divide unit, one bit per cycle.
//               Holds the control FSM, iteration counter, handshake and the
//               registered result; arithmetic lives in mul_div_datapath.
// Ports       : clk   - rising-edge clock
//               rst_n - synchronous active-low reset
//               valid - request strobe, sampled only in IDLE
//               mode  - 0 = MUL, 1 = DIV
//               in_A  - multiplicand / dividend
//               in_B  - multiplier / divisor
//               ready - one-cycle pulse, out holds a fresh result
//               busy  - operation in progress (acceptance through DONE)
//               out   - MUL: product, DIV: {remainder, quotient}
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_iter
    import mul_div_iter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     in_A,
    input  logic [WIDTH-1:0]     in_B,
    output logic                 ready,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   out
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH);

    state_e               r_state_q;
    state_e               w_state_d;
    logic [CNT_W-1:0]     r_cnt_q;
    logic [CNT_W-1:0]     w_cnt_d;
    logic [2*WIDTH-1:0]   r_out_q;
    logic [2*WIDTH-1:0]   w_out_d;

    logic                 w_load;
    logic                 w_step;
    logic                 w_op;
    logic [2*WIDTH-1:0]   w_acc;

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_out_d   = r_out_q;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_op      = (r_state_q == S_DIV) ? MODE_DIV : MODE_MUL;

        case (r_state_q)
            S_IDLE: begin
                if (valid) begin
                    w_load    = 1'b1;
                    w_op      = mode;
                    w_cnt_d   = '0;
                    w_state_d = (mode == MODE_DIV) ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                // Counter reaching WIDTH means all iterations are in the
                // accumulator; this edge publishes it without stepping.
                if (r_cnt_q == C_LAST) begin
                    w_out_d   = w_acc;
                    w_state_d = S_DONE;
                end else begin
                    w_step  = 1'b1;
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
            r_out_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_out_q   <= w_out_d;
        end
    end

    mul_div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (w_load),
        .step_i (w_step),
        .op_i   (w_op),
        .a_i    (in_A),
        .b_i    (in_B),
        .acc_o  (w_acc)
    );

    assign ready = (r_state_q == S_DONE);
    assign busy  = (r_state_q != S_IDLE);
    assign out   = r_out_q;

endmodule : mul_div_iter
`default_nettype wire

// File: tb/tb_mul_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_iter
// Description : Self-checking bench for mul_div_iter. Directed scenarios plus
//               randomized operations compared against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_iter;

    localparam int C_LAT = 33;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        mode  = 1'b0;
    logic [31:0] in_A  = '0;
    logic [31:0] in_B  = '0;
    logic        ready;
    logic        busy;
    logic [63:0] out;

    int errors = 0;
    int checks = 0;

    mul_div_iter #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (valid),
        .mode  (mode),
        .in_A  (in_A),
        .in_B  (in_B),
        .ready (ready),
        .busy  (busy),
        .out   (out)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned arithmetic, RISC-V divide-by-zero convention.
    function automatic logic [63:0] model(input logic m, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (!m) begin
            p = 64'(a) * 64'(b);
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    // Drive one request in IDLE; returns just after the acceptance edge with
    // the inputs scrambled so later operand changes cannot matter.
    task automatic issue(input logic m, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid = 1'b1;
        mode  = m;
        in_A  = a;
        in_B  = b;
        @(posedge clk);
        #1;
        valid = 1'b0;
        mode  = 1'($urandom);
        in_A  = $urandom;
        in_B  = $urandom;
    endtask

    // Count edges until ready is seen (bounded); -1 on timeout.
    task automatic wait_ready(output int lat);
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out !== 64'd0) begin errors++; $display("FAIL reset_out: got %h expected %h", out, 64'd0); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul_basic;
        int lat;
        issue(1'b0, 32'd7, 32'd6);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy_after_accept: got %b expected 1", busy); end
        wait_ready(lat);
        checks++; if (lat != C_LAT) begin errors++; $display("FAIL mul_latency: got %0d expected %0d", lat, C_LAT); end
        checks++; if (out !== 64'h2A) begin errors++; $display("FAIL mul_7x6: got %h expected %h", out, 64'h2A); end
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mul_ready_pulse: got %b expected 0", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_after_done: got %b expected 0", busy); end
        checks++; if (out !== 64'h2A) begin errors++; $display("FAIL mul_out_held: got %h expected %h", out, 64'h2A); end
    endtask

    task automatic test_directed;
        logic        m_t [5];
        logic [31:0] a_t [5];
        logic [31:0] b_t [5];
        logic [63:0] e_t [5];
        int lat;
        m_t[0] = 1'b0; a_t[0] = 32'hFFFF_FFFF; b_t[0] = 32'hFFFF_FFFF; e_t[0] = 64'hFFFF_FFFE_0000_0001;
        m_t[1] = 1'b1; a_t[1] = 32'd100;       b_t[1] = 32'd7;         e_t[1] = 64'h0000_0002_0000_000E;
        m_t[2] = 1'b1; a_t[2] = 32'd5;         b_t[2] = 32'd9;         e_t[2] = 64'h0000_0005_0000_0000;
        m_t[3] = 1'b1; a_t[3] = 32'h1234_5678; b_t[3] = 32'd0;         e_t[3] = 64'h1234_5678_FFFF_FFFF;
        m_t[4] = 1'b1; a_t[4] = 32'hFFFF_FFFF; b_t[4] = 32'd1;         e_t[4] = 64'h0000_0000_FFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            issue(m_t[i], a_t[i], b_t[i]);
            wait_ready(lat);
            checks++; if (lat != C_LAT) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, C_LAT); end
            checks++; if (out !== e_t[i]) begin errors++; $display("FAIL directed_out[%0d]: got %h expected %h", i, out, e_t[i]); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_busy_ignore;
        int pulses = 0;
        int first  = -1;
        logic [63:0] got = '0;
        issue(1'b0, 32'd3, 32'd4);
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                pulses++;
                if (first < 0) begin first = k; got = out; end
            end
            if (k >= 4 && k <= 9) begin
                valid = 1'b1; mode = 1'b1; in_A = 32'hDEAD; in_B = 32'hBEEF;
            end else begin
                valid = 1'b0;
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
        checks++; if (first != C_LAT) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", first, C_LAT); end
        checks++; if (got !== 64'hC) begin errors++; $display("FAIL ignore_out: got %h expected %h", got, 64'hC); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_second_op: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [63:0] exp2;
        issue(1'b0, 32'h0001_0003, 32'h0000_0101);
        wait_ready(lat);
        // Request raised during DONE and held: must not be taken until IDLE.
        valid = 1'b1; mode = 1'b1; in_A = 32'd1000; in_B = 32'd33;
        exp2 = model(1'b1, 32'd1000, 32'd33);
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_accept_in_done: got %b expected 0", busy); end
        @(posedge clk);
        #1;
        valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_in_idle: got %b expected 1", busy); end
        wait_ready(lat);
        checks++; if (lat != C_LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, C_LAT); end
        checks++; if (out !== exp2) begin errors++; $display("FAIL b2b_out: got %h expected %h", out, exp2); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int lat;
        issue(1'b1, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (out !== 64'd0) begin errors++; $display("FAIL midreset_out: got %h expected %h", out, 64'd0); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b expected 0", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        issue(1'b0, 32'd2, 32'd3);
        wait_ready(lat);
        checks++; if (lat != C_LAT) begin errors++; $display("FAIL midreset_latency: got %0d expected %0d", lat, C_LAT); end
        checks++; if (out !== 64'd6) begin errors++; $display("FAIL midreset_mul_2x3: got %h expected %h", out, 64'd6); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        int lat;
        logic        m;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] e;
        for (int i = 0; i < 24; i++) begin
            m = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
            e = model(m, a, b);
            issue(m, a, b);
            wait_ready(lat);
            checks++; if (lat != C_LAT) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, C_LAT); end
            checks++; if (out !== e) begin errors++; $display("FAIL rand_out[%0d] m=%b a=%h b=%h: got %h expected %h", i, m, a, b, out, e); end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset;
        test_mul_basic;
        test_directed;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mul_div_iter
`default_nettype wire
